// File: rtl/ceespu_text_renderer_if.sv
// ceespu_text_renderer_if: timing, memory and pixel signals of the text renderer.
// Ports (bundle): x/y/de/hsync/vsync timing in, scroll_row, text RAM (text_addr/text_data),
// font ROM (font_addr/font_data), colour/video_de/video_hsync/video_vsync out.
// cursor_col/cursor_row/cursor_on exist only when CEESPU_GPU_CURSOR_EN is defined.
// master = timing generator, memories and display sink; slave = renderer.
interface ceespu_text_renderer_if #(
   parameter int COLS = 80,
   parameter int ROWS = 30,
   parameter int GLYPH_H = 16,
   parameter int X_W = 10,
   parameter int Y_W = 9,
   parameter int ADDR_W = 12
);
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic de, hsync, vsync;
   logic [$clog2(ROWS)-1:0] scroll_row;
   logic [ADDR_W-1:0] text_addr;
   logic [15:0] text_data;
   logic [7+$clog2(GLYPH_H):0] font_addr;
   logic [7:0] font_data;
   logic [3:0] colour;
   logic video_de, video_hsync, video_vsync;
`ifdef CEESPU_GPU_CURSOR_EN
   logic [$clog2(COLS)-1:0] cursor_col;
   logic [$clog2(ROWS)-1:0] cursor_row;
   logic cursor_on;
   modport master(output x, y, de, hsync, vsync, scroll_row, text_data, font_data, cursor_col, cursor_row, cursor_on,
                  input text_addr, font_addr, colour, video_de, video_hsync, video_vsync);
   modport slave(input x, y, de, hsync, vsync, scroll_row, text_data, font_data, cursor_col, cursor_row, cursor_on,
                 output text_addr, font_addr, colour, video_de, video_hsync, video_vsync);
`else
   modport master(output x, y, de, hsync, vsync, scroll_row, text_data, font_data,
                  input text_addr, font_addr, colour, video_de, video_hsync, video_vsync);
   modport slave(input x, y, de, hsync, vsync, scroll_row, text_data, font_data,
                 output text_addr, font_addr, colour, video_de, video_hsync, video_vsync);
`endif
endinterface

// File: rtl/ceespu_text_renderer.sv
// ceespu_text_renderer: 3-cycle text-mode pixel pipeline (coordinates -> 4-bit palette index).
// Ports: clk pixel clock, rst async active-high reset, bus (slave modport) carrying timing in,
// text RAM / font ROM addresses (combinational) and data (1-cycle sync memories),
// registered colour and 3-cycle-delayed de/hsync/vsync.
// Optional hardware cursor built only when CEESPU_GPU_CURSOR_EN is defined.
module ceespu_text_renderer #(
   parameter int COLS = 80,
   parameter int ROWS = 30,
   parameter int GLYPH_H = 16,
   parameter int X_W = 10,
   parameter int Y_W = 9,
   parameter int ADDR_W = 12,
   parameter int BLINK_LOG2 = 5
) (
   input logic clk,
   input logic rst,
   ceespu_text_renderer_if.slave bus
);
   localparam int GL = $clog2(GLYPH_H);
   localparam int CX = X_W - 3;
   localparam int RY = Y_W - GL;
   localparam int RW = $clog2(ROWS);
   localparam int SW = (RY > RW ? RY : RW) + 1;
   logic [CX-1:0] col;
   logic [RY-1:0] trow;
   logic [GL-1:0] gy, gy1;
   logic [SW-1:0] sum, srow;
   logic [RW-1:0] scroll_q;
   logic [BLINK_LOG2-1:0] frame_cnt;
   logic [2:0] gx1, gx2, bg2;
   logic [3:0] fg2, fg;
   logic [1:0] de_p, hs_p, vs_p;
   logic in_area, vs_d, act1, act2, blink2, pix, phase, cur;
   assign col = bus.x[X_W-1:3];
   assign trow = bus.y[Y_W-1:GL];
   assign gy = bus.y[GL-1:0];
   // single wrap is enough: both trow and scroll_q are below ROWS when in_area
   always_comb begin
      in_area = 32'(col) < COLS && 32'(trow) < ROWS;
      sum = SW'(trow) + SW'(scroll_q);
      srow = 32'(sum) >= ROWS ? sum - SW'(ROWS) : sum;
      bus.text_addr = in_area ? ADDR_W'(32'(srow) * COLS + 32'(col)) : '0;
   end
   assign bus.font_addr = {bus.text_data[7:0], gy1};
   assign phase = frame_cnt[BLINK_LOG2-1];
   assign pix = bus.font_data[~gx2] | (cur & ~phase);
   assign fg = blink2 && phase ? {1'b0, bg2} : fg2;
   // scroll and blink counter only move on a vsync rising edge so a frame never tears
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vs_d <= 1'b0;
         scroll_q <= '0;
         frame_cnt <= '0;
      end else begin
         vs_d <= bus.vsync;
         if (bus.vsync && !vs_d) begin
            scroll_q <= 32'(bus.scroll_row) < ROWS ? bus.scroll_row : '0;
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {gx1, gy1, act1, gx2, act2, fg2, bg2, blink2} <= '0;
         {de_p, hs_p, vs_p} <= '0;
         bus.colour <= 4'h0;
         bus.video_de <= 1'b0;
         bus.video_hsync <= 1'b0;
         bus.video_vsync <= 1'b0;
      end else begin
         gx1 <= bus.x[2:0];
         gy1 <= gy;
         act1 <= bus.de && in_area;
         gx2 <= gx1;
         act2 <= act1;
         fg2 <= bus.text_data[11:8];
         bg2 <= bus.text_data[14:12];
         blink2 <= bus.text_data[15];
         de_p <= {de_p[0], bus.de};
         hs_p <= {hs_p[0], bus.hsync};
         vs_p <= {vs_p[0], bus.vsync};
         bus.colour <= act2 ? (pix ? fg : {1'b0, bg2}) : 4'h0;
         bus.video_de <= de_p[1];
         bus.video_hsync <= hs_p[1];
         bus.video_vsync <= vs_p[1];
      end
`ifdef CEESPU_GPU_CURSOR_EN
   // cursor hit is decided on the screen position (pre-scroll) and carried alongside stages 1/2
   logic cur1, cur2;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cur1 <= 1'b0;
         cur2 <= 1'b0;
      end else begin
         cur1 <= bus.cursor_on && 32'(col) == 32'(bus.cursor_col) && 32'(trow) == 32'(bus.cursor_row)
                 && 32'(gy) >= GLYPH_H - 2;
         cur2 <= cur1;
      end
   assign cur = cur2;
`else
   assign cur = 1'b0;
`endif
endmodule

// File: tb/tb_ceespu_text_renderer.sv
// tb_ceespu_text_renderer: random pixel stream checked against a behavioural screen model via a scoreboard.
module tb_ceespu_text_renderer;
   localparam int COLS = 80, ROWS = 30, GLYPH_H = 16, X_W = 10, Y_W = 9, ADDR_W = 12, BLINK_LOG2 = 5;
   localparam int RW = $clog2(ROWS);
   typedef struct {
      int due;
      logic [3:0] c;
      logic de, hs, vs;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   ceespu_text_renderer_if #(.COLS(COLS), .ROWS(ROWS), .GLYPH_H(GLYPH_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) bus();
   ceespu_text_renderer #(.COLS(COLS), .ROWS(ROWS), .GLYPH_H(GLYPH_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W),
                          .BLINK_LOG2(BLINK_LOG2)) dut (.clk(clk), .rst(rst), .bus(bus));
   logic [15:0] tram [4096];
   logic [7:0] from [4096];
   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0, scroll_m = 0, frame_m = 0;
   logic vs_prev = 1'b0;
   always @(posedge clk) begin
      bus.text_data <= tram[bus.text_addr];
      bus.font_data <= from[bus.font_addr];
      cyc <= cyc + 1;
   end
   // screen model: what the pixel at (x,y) should look like given the current scroll and frame count
   function automatic logic [3:0] model(int x, int y, logic de);
      int col = x / 8, row = y / GLYPH_H, gy = y % GLYPH_H, gx = x % 8;
      logic [15:0] w;
      logic [7:0] f;
      logic [3:0] fg, bg;
      logic pix, ph;
      if (!de || col >= COLS || row >= ROWS) return 4'h0;
      w = tram[((row + scroll_m) % ROWS) * COLS + col];
      f = from[int'(w[7:0]) * GLYPH_H + gy];
      ph = ((frame_m >> (BLINK_LOG2 - 1)) & 1) == 1;
      pix = f[7 - gx];
      fg = w[11:8];
      bg = {1'b0, w[14:12]};
      if (w[15] && ph) fg = bg;
`ifdef CEESPU_GPU_CURSOR_EN
      if (bus.cursor_on && !ph && col == int'(bus.cursor_col) && row == int'(bus.cursor_row) && gy >= GLYPH_H - 2) begin
         pix = 1'b1;
         fg = w[11:8];
      end
`endif
      return pix ? fg : bg;
   endfunction
   task automatic drive(int x, int y, logic de, logic vs);
      int col = x / 8, row = y / GLYPH_H, ea;
      logic hs;
      hs = 1'($urandom);
      @(negedge clk);
      bus.x = X_W'(x);
      bus.y = Y_W'(y);
      bus.de = de;
      bus.hsync = hs;
      bus.vsync = vs;
      #1;
      ea = (col < COLS && row < ROWS) ? ((row + scroll_m) % ROWS) * COLS + col : 0;
      checks++;
      if (int'(bus.text_addr) != ea) begin
         errors++;
         $display("FAIL text_addr x=%0d y=%0d got %0d expected %0d", x, y, bus.text_addr, ea);
      end
      q.push_back('{due: cyc + 3, c: model(x, y, de), de: de, hs: hs, vs: vs});
      if (vs && !vs_prev) begin
         frame_m++;
         scroll_m = int'(bus.scroll_row) < ROWS ? int'(bus.scroll_row) : 0;
      end
      vs_prev = vs;
   endtask
   task automatic check_zero(string name);
      checks++;
      if (bus.colour !== 4'h0 || bus.video_de !== 1'b0 || bus.video_hsync !== 1'b0 || bus.video_vsync !== 1'b0) begin
         errors++;
         $display("FAIL %s got colour=%h de=%b hs=%b vs=%b expected all 0", name, bus.colour, bus.video_de,
                  bus.video_hsync, bus.video_vsync);
      end
   endtask
   // one frame: idle margin around the vsync pulse, directed pixels, mid-frame scroll change, random pixels
   task automatic frame();
      int s;
      repeat (3) drive(0, 0, 1'b0, 1'b0);
      repeat (3) drive(0, 0, 1'b0, 1'b1);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b1, 1'b0);
      drive(1, 0, 1'b1, 1'b0);
      drive(40, ((ROWS - scroll_m) % ROWS) * GLYPH_H, 1'b1, 1'b0);
      drive(639, 479, 1'b1, 1'b0);
      drive(640, 0, 1'b1, 1'b0);
      case ($urandom_range(0, 3))
         0: s = 0;
         1: s = 29;
         2: s = 31;
         default: s = $urandom_range(0, ROWS - 1);
      endcase
      bus.scroll_row = RW'(s);
      drive(0, 0, 1'b1, 1'b0);
      drive(0, 16, 1'b1, 1'b0);
      repeat (20) drive($urandom_range(0, 700), $urandom_range(0, 511), $urandom_range(0, 7) != 0, 1'b0);
`ifdef CEESPU_GPU_CURSOR_EN
      bus.cursor_on = $urandom_range(0, 3) != 0;
      for (int i = 16; i < 24; i++) drive(i, 30, 1'b1, 1'b0);
      for (int i = 16; i < 24; i++) drive(i, 29, 1'b1, 1'b0);
`endif
      drive(0, 0, 1'b0, 1'b0);
   endtask
   always @(posedge clk) begin : mon
      exp_t e;
      #2;
      if (!rst && q.size() != 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         checks++;
         if (e.due != cyc || bus.colour !== e.c || bus.video_de !== e.de || bus.video_hsync !== e.hs
             || bus.video_vsync !== e.vs) begin
            errors++;
            $display("FAIL pixel cycle=%0d due=%0d got colour=%h de=%b hs=%b vs=%b expected colour=%h de=%b hs=%b vs=%b",
                     cyc, e.due, bus.colour, bus.video_de, bus.video_hsync, bus.video_vsync, e.c, e.de, e.hs, e.vs);
         end
      end
   end
   initial begin
      for (int i = 0; i < 4096; i++) begin
         tram[i] = 16'($urandom);
         from[i] = 8'($urandom);
      end
      tram[0] = 16'h0A41;
      tram[5] = 16'h9F41;
      tram[82] = 16'h0720;
      from[12'h410] = 8'h80;
      from[12'h20E] = 8'h00;
      from[12'h20F] = 8'h00;
      bus.x = '0;
      bus.y = '0;
      bus.de = 1'b0;
      bus.hsync = 1'b0;
      bus.vsync = 1'b0;
      bus.scroll_row = '0;
`ifdef CEESPU_GPU_CURSOR_EN
      bus.cursor_col = 7'd2;
      bus.cursor_row = 5'd1;
      bus.cursor_on = 1'b1;
`endif
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst = 1'b0;
      repeat (50) frame();
      for (int i = 96; i <= 100; i++) drive(i, 40, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero("mid_line_reset");
      q.delete();
      frame_m = 0;
      scroll_m = 0;
      vs_prev = 1'b0;
      bus.vsync = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset_hold");
      rst = 1'b0;
      repeat (3) frame();
      repeat (6) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending outputs expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ceespu_text_renderer.md
Name: ceespu_text_renderer

Overview:
- Parametrised text-mode pixel pipeline for the ceespu GPU; successor to the fixed 80x30 text path.
- Converts pixel coordinates from the HDMI timing generator into a 4-bit palette index, with fixed 3-cycle latency and delayed sync/DE alignment.
- Adds configurable grid size and glyph height, per-cell 16-bit attributes, blink, frame-latched hardware row scroll and optional hardware cursor.
- Text RAM and font ROM sit outside the block as 1-cycle-latency synchronous memories on the same clock.

Parameters:
- COLS, 80, text columns.
- ROWS, 30, text rows.
- GLYPH_H, 16, glyph height in lines (8 or 16); glyph width is fixed at 8.
- X_W, 10, width of the x coordinate.
- Y_W, 9, width of the y coordinate.
- ADDR_W, 12, text RAM address width; must satisfy COLS*ROWS <= 2^ADDR_W.
- BLINK_LOG2, 5, blink period is 2^BLINK_LOG2 frames; phase = frame_cnt[BLINK_LOG2-1].

Ports:
- I_clk  in  1  pixel clock
- I_rst  in  1  asynchronous reset, active-high
- I_x  in  X_W  pixel column
- I_y  in  Y_W  pixel line
- I_de  in  1  display enable
- I_hsync  in  1  hsync
- I_vsync  in  1  vsync, active-high
- I_scroll_row  in  clog2(ROWS)  first displayed text row
- O_text_addr  out  ADDR_W  text RAM read address, combinational
- I_text_data  in  16  cell word: [7:0] char, [11:8] fg, [14:12] bg, [15] blink
- O_font_addr  out  8+clog2(GLYPH_H)  font ROM address, combinational
- I_font_data  in  8  glyph line; bit 7 = leftmost pixel
- I_cursor_col  in  clog2(COLS)  cursor column (CURSOR_EN only)
- I_cursor_row  in  clog2(ROWS)  cursor screen row (CURSOR_EN only)
- I_cursor_on  in  1  cursor visible (CURSOR_EN only)
- O_colour  out  4  palette index, registered
- O_de  out  1  I_de delayed 3 cycles
- O_hsync  out  1  I_hsync delayed 3 cycles
- O_vsync  out  1  I_vsync delayed 3 cycles

Behaviour:
- Reset: O_colour, O_de, O_hsync and O_vsync are 0. All pipeline registers, the scroll latch and frame_cnt are 0. Asserting reset mid-frame clears the pipeline immediately. Valid output resumes 3 cycles after the first post-release input.
- Cycle N, combinational:
  - col = I_x>>3, glyph_x = I_x[2:0]
  - trow = I_y / GLYPH_H, glyph_y = I_y mod GLYPH_H
  - in_area = col<COLS && trow<ROWS
  - srow = trow + scroll_q; if srow>=ROWS then srow -= ROWS (single wrap)
  - O_text_addr = srow*COLS + col; forced to 0 when !in_area
- Stage 1 (registered at end of N): glyph_x, glyph_y, de&&in_area, col, trow, sync bits.
- Cycle N+1: I_text_data is valid. O_font_addr = char*GLYPH_H + glyph_y_s1.
- Stage 2 (registered at end of N+1): attribute fields, plus everything from stage 1.
- Cycle N+2: I_font_data is valid. pix = I_font_data[7-glyph_x_s2].
- Stage 3 (registered at end of N+2):
  - O_colour = pix ? fg : {1'b0,bg}
  - Blink: if blink attribute set and blink phase is 1, fg is replaced by {1'b0,bg}.
  - If not (de&&in_area), O_colour = 0.
- Latency is exactly 3 cycles, for every field.
- Scroll latch: scroll_q <= I_scroll_row on the rising edge of I_vsync (registered edge detect), so a scroll change never tears a frame. I_scroll_row >= ROWS latches as 0.
- frame_cnt (BLINK_LOG2 bits) increments on each I_vsync rising edge and wraps from all-ones to 0.
- Simultaneous vsync edge and reset: reset wins.
- Coordinates beyond the grid (e.g. x>=COLS*8) output index 0 while DE passes through unchanged.

Optional Feature:
- Macro: CEESPU_GPU_CURSOR_EN.
- Defined:
  - Cursor cell is col==I_cursor_col && trow==I_cursor_row (screen position, before scroll).
  - Cursor covers glyph lines GLYPH_H-2 and GLYPH_H-1.
  - On those lines, while I_cursor_on is set and blink phase is 0, pix is forced to 1 and fg is used even if the cell's blink attribute is set.
  - Compare results are pipelined with stage 1/2, so latency stays 3.
- Not defined: the cursor ports are absent and no cursor logic is built.

Test Plan:
- Reset then x=0,y=0,de=1; text[0]=16'h0A41; font('A',0)=8'h80 -> O_colour=4'hA exactly 3 cycles later, then x=1 gives 4'h0 (bg 0); O_de rises in the same cycle.
- COLS=80,ROWS=30,GLYPH_H=16: x=639,y=479 -> O_text_addr=2399; x=640,y=0 with de=1 -> O_text_addr=0, O_colour=0 after 3 cycles, O_de=1.
- I_scroll_row=29 set mid-frame -> addresses unchanged until the vsync rising edge; next frame y=0 -> O_text_addr=29*80=2320, y=16 -> O_text_addr=0 (wrap).
- Cell word 16'h9F41 with foreground pixel set: after 16 vsync edges (BLINK_LOG2=5) -> O_colour=4'h1 (bg), before them 4'hF; 32 edges -> back to 4'hF.
- Assert I_rst at x=100 mid-line -> O_colour, O_de, O_hsync and O_vsync are 0 the same cycle; after release, the first valid pixel appears 3 cycles after it is presented; frame_cnt restarts from 0.
- CEESPU_GPU_CURSOR_EN, cursor (2,1), on, phase 0: y=30 (line 14), x=16..23 over a blank glyph with fg=7 -> O_colour=7 for all 8 pixels; y=29 -> bg only.
